ps2_kbd_rx_fifo: RTL and testbench

PS/2 keyboard front end that deserialises device-to-host frames and buffers scan-code bytes for the CPU. It sits directly upstream of the bus keyboard port and drives its key_data, ready and overflow inputs. The CPU pops bytes with the active-low io_rdn strobe. Replaces the unbuffered receiver and adds glitch filtering, frame validation and a stall timeout.

---
 rtl/ps2_kbd_rx_fifo_if.sv | 35 +++
 rtl/ps2_kbd_rx_fifo.sv | 240 ++++++++++++++++++++++++
 tb/tb_ps2_kbd_rx_fifo.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// ps2_kbd_rx_fifo_if
// CPU-side keyboard port between the PS/2 receiver FIFO and the bus.
//   io_rdn     : CPU read strobe, active-low (a high-to-low transition pops)
//   key_data   : FIFO head byte, first-word fall-through
//   ready      : FIFO holds at least one byte
//   overflow   : sticky, a valid frame was dropped on a full FIFO
//   parity_err : sticky, a frame failed its parity/stop check
// Modports:
//   master : CPU / bus side (drives io_rdn)
//   slave  : receiver side (drives the status and data)
// ---------------------------------------------------------------------------
interface ps2_kbd_rx_fifo_if;
    logic       io_rdn;
    logic [7:0] key_data;
    logic       ready;
    logic       overflow;
    logic       parity_err;

    modport master (
        output io_rdn,
        input  key_data,
        input  ready,
        input  overflow,
        input  parity_err
    );

    modport slave (
        input  io_rdn,
        output key_data,
        output ready,
        output overflow,
        output parity_err
    );
endinterface

// File: rtl/ps2_kbd_rx_fifo.sv
// ---------------------------------------------------------------------------
// ps2_kbd_rx_fifo
// PS/2 keyboard front end: synchronises and glitch-filters the pad clock,
// deserialises 11-bit device-to-host frames (start, D0..D7 LSB first, odd
// parity, stop), and buffers received scan-code bytes in a small FIFO that
// the CPU drains with an edge-detected active-low read strobe.
//
// Ports:
//   clk      : system clock, rising edge
//   rst      : synchronous reset, active-high
//   ps2_clk  : raw PS/2 clock from the pad (asynchronous)
//   ps2_data : raw PS/2 data from the pad (asynchronous)
//   bus      : ps2_kbd_rx_fifo_if.slave (io_rdn in; key_data, ready,
//              overflow, parity_err out)
//
// Optional feature macro: PS2_PARITY_CHECK_EN
//   defined   : frames with bad odd parity or stop=0 are discarded and set
//               the sticky parity_err flag
//   undefined : every complete 11-bit frame is pushed, parity_err is 0
// ---------------------------------------------------------------------------
module ps2_kbd_rx_fifo #(
    parameter int FIFO_AW        = 3,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    ps2_kbd_rx_fifo_if.slave      bus
);
    localparam int                 DEPTH    = 2 ** FIFO_AW;
    localparam int                 TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [TW-1:0]      TMO      = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    // ---- Stage: pad synchronisers ----
    logic [1:0] clk_sync;
    logic [1:0] dat_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    // ---- Stage: clock glitch filter ----
    // The filtered level only moves once the last FILTER_LEN synchronised
    // samples all agree; anything shorter is treated as a glitch.
    logic [FILTER_LEN-1:0] clk_hist;
    logic                  clk_filt;
    logic                  fall;
    logic                  rx_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_hist <= '1;
            clk_filt <= 1'b1;
        end else begin
            clk_hist <= {clk_hist[FILTER_LEN-2:0], clk_sync[1]};
            if (&clk_hist)
                clk_filt <= 1'b1;
            else if (~|clk_hist)
                clk_filt <= 1'b0;
        end
    end

    // Falling edge is flagged in the cycle the filter decides to go low.
    assign fall   = clk_filt & ~|clk_hist;
    assign rx_bit = dat_sync[1];

    // ---- Stage: frame FSM ----
    state_t          state;
    logic [3:0]      bitcnt;
    logic [TW-1:0]   tcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            bitcnt <= 4'd0;
            tcnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tcnt <= '0;
                    // A falling edge with data high is a false start.
                    if (fall && !rx_bit) begin
                        state  <= S_RECV;
                        bitcnt <= 4'd1;
                    end
                end
                S_RECV: begin
                    if (fall) begin
                        tcnt   <= '0;
                        bitcnt <= bitcnt + 4'd1;
                        if (bitcnt == 4'd10)
                            state <= S_CHECK;
                    end else if (tcnt == TMO) begin
                        // Stalled device: drop the partial frame silently.
                        state  <= S_IDLE;
                        bitcnt <= 4'd0;
                        tcnt   <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    state  <= S_IDLE;
                    bitcnt <= 4'd0;
                    tcnt   <= '0;
                end
                default: begin
                    state  <= S_IDLE;
                    bitcnt <= 4'd0;
                    tcnt   <= '0;
                end
            endcase
        end
    end

    // Frame payload capture; bit index follows bitcnt (1..8 data,
    // 9 parity, 10 stop).
    logic [7:0] rx_byte;
`ifdef PS2_PARITY_CHECK_EN
    logic       rx_par;
    logic       rx_stop;
`endif

    always_ff @(posedge clk) begin
        if (state == S_RECV && fall) begin
            case (bitcnt)
                4'd1, 4'd2, 4'd3, 4'd4,
                4'd5, 4'd6, 4'd7, 4'd8: rx_byte[3'(bitcnt - 4'd1)] <= rx_bit;
`ifdef PS2_PARITY_CHECK_EN
                4'd9:                   rx_par  <= rx_bit;
                4'd10:                  rx_stop <= rx_bit;
`endif
                default: ;
            endcase
        end
    end

    // ---- Stage: frame check and FIFO ----
    logic frame_ok;
    logic push_req;

`ifdef PS2_PARITY_CHECK_EN
    // Odd parity: data plus parity bit must contain an odd number of ones.
    assign frame_ok = (^{rx_par, rx_byte}) & rx_stop;
`else
    assign frame_ok = 1'b1;
`endif
    assign push_req = (state == S_CHECK) & frame_ok;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               rdn_q;
    logic [7:0]         last_pop;
    logic               overflow_r;
    logic               not_empty;
    logic               full;
    logic               pop;
    logic               push;
    logic               drop;

    assign not_empty = (count != '0);
    assign full      = (count == CNT_FULL);
    assign pop       = rdn_q & ~bus.io_rdn & not_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push      = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rdn_q      <= 1'b1;
            last_pop   <= 8'h00;
            overflow_r <= 1'b0;
        end else begin
            rdn_q <= bus.io_rdn;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                last_pop <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (drop)
                overflow_r <= 1'b1;
            else if (pop)
                overflow_r <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= rx_byte;
    end

`ifdef PS2_PARITY_CHECK_EN
    logic parity_err_r;

    always_ff @(posedge clk) begin
        if (rst)
            parity_err_r <= 1'b0;
        else if (state == S_CHECK && !frame_ok)
            parity_err_r <= 1'b1;
        else if (push)
            parity_err_r <= 1'b0;
    end

    assign bus.parity_err = parity_err_r;
`else
    assign bus.parity_err = 1'b0;
`endif

    // When empty, the last popped byte stays visible.
    assign bus.key_data = not_empty ? mem[rd_ptr] : last_pop;
    assign bus.ready    = not_empty;
    assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_ps2_kbd_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_ps2_kbd_rx_fifo
// Self-checking bench for ps2_kbd_rx_fifo. PS/2 frames are bit-banged on the
// pad inputs; a queue-based model of the receiver's byte stream predicts
// key_data, ready, overflow and parity_err.
// ---------------------------------------------------------------------------
module tb_ps2_kbd_rx_fifo;
    localparam int FIFO_AW        = 3;
    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 5000;
    localparam int DEPTH          = 2 ** FIFO_AW;
    // Pad falling edge to push-visible: 2 sync + filter window, then N+2.
    localparam int LAT            = 2 + FILTER_LEN + 2;

    logic clk = 1'b0;
    logic rst;
    logic ps2_clk;
    logic ps2_data;

    ps2_kbd_rx_fifo_if bus ();

    ps2_kbd_rx_fifo #(
        .FIFO_AW       (FIFO_AW),
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: byte queue plus sticky flags.
    logic [7:0] mq[$];
    logic [7:0] m_last;
    logic       m_ovf;
    logic       m_perr;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] m_head();
        return (mq.size() != 0) ? mq[0] : m_last;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_last = 8'h00;
        m_ovf  = 1'b0;
        m_perr = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] b, input logic bad);
`ifdef PS2_PARITY_CHECK_EN
        if (bad) begin
            m_perr = 1'b1;
            return;
        end
`endif
        if (mq.size() == DEPTH) begin
            m_ovf = 1'b1;
        end else begin
            mq.push_back(b);
            m_perr = 1'b0;
        end
    endtask

    task automatic model_pop();
        if (mq.size() != 0) begin
            m_last = mq.pop_front();
            m_ovf  = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        model_reset();
        cyc(2);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        cyc(4);
        ps2_clk = 1'b0;
        cyc(8);
        ps2_clk = 1'b1;
        cyc(4);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_data = 1'b1;
        cyc(4);
        model_frame(b, bad_par | bad_stop);
    endtask

    task automatic pop_pulse(input int len);
        bus.io_rdn = 1'b0;
        cyc(len);
        bus.io_rdn = 1'b1;
        cyc(2);
        model_pop();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got=%b want=0", bus.ready); end
        vectors++;
        if (bus.key_data !== 8'h00) begin miscompares++; $display("FAIL reset_key got=%h want=00", bus.key_data); end
        vectors++;
        if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got=%b want=0", bus.overflow); end
        vectors++;
        if (bus.parity_err !== 1'b0) begin miscompares++; $display("FAIL reset_perr got=%b want=0", bus.parity_err); end
    endtask

    task automatic test_single_frame();
        logic [7:0] b;
        int seen;
        b = 8'h1C;
        do_reset();
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(1'b0);              // parity of 0x1C (three ones) is 0
        ps2_data = 1'b1;            // stop bit, watched edge by edge
        cyc(4);
        ps2_clk = 1'b0;
        seen = -1;
        for (int i = 1; i <= 16; i++) begin
            cyc(1);
            if (bus.ready === 1'b1 && seen < 0) seen = i;
        end
        ps2_clk = 1'b1;
        cyc(4);
        model_frame(b, 1'b0);
        vectors++;
        if (seen != LAT) begin miscompares++; $display("FAIL single_latency got=%0d want=%0d", seen, LAT); end
        vectors++;
        if (bus.key_data !== m_head()) begin miscompares++; $display("FAIL single_key got=%h want=%h", bus.key_data, m_head()); end
        pop_pulse(20);
        vectors++;
        if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL single_pop_ready got=%b want=0", bus.ready); end
        vectors++;
        if (bus.key_data !== 8'h1C) begin miscompares++; $display("FAIL single_hold_key got=%h want=1c", bus.key_data); end
    endtask

    task automatic test_make_break();
        do_reset();
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        vectors++;
        if (bus.key_data !== 8'hF0) begin miscompares++; $display("FAIL mb_first got=%h want=f0", bus.key_data); end
        vectors++;
        if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL mb_ovf got=%b want=0", bus.overflow); end
        pop_pulse(20);              // long strobe must pop exactly once
        vectors++;
        if (bus.ready !== 1'b1 || bus.key_data !== 8'h1C) begin
            miscompares++; $display("FAIL mb_second got=%b/%h want=1/1c", bus.ready, bus.key_data);
        end
        pop_pulse(3);
        vectors++;
        if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL mb_empty got=%b want=0", bus.ready); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b0);
        send_frame(8'h09, 1'b0, 1'b0);
        vectors++;
        if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set got=%b want=1", bus.overflow); end
        vectors++;
        if (bus.key_data !== 8'h01) begin miscompares++; $display("FAIL ovf_head got=%h want=01", bus.key_data); end
        for (int i = 1; i <= 8; i++) begin
            vectors++;
            if (bus.key_data !== 8'(i)) begin miscompares++; $display("FAIL ovf_read%0d got=%h want=%h", i, bus.key_data, 8'(i)); end
            pop_pulse(2);
            if (i == 1) begin
                vectors++;
                if (bus.overflow !== m_ovf) begin miscompares++; $display("FAIL ovf_clear got=%b want=%b", bus.overflow, m_ovf); end
            end
        end
        vectors++;
        if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL ovf_drained got=%b want=0", bus.ready); end
    endtask

    task automatic test_full_pop();
        logic [7:0] b;
        b = 8'h0A;
        do_reset();
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b);
        ps2_data = 1'b1;
        cyc(4);
        ps2_clk = 1'b0;
        cyc(LAT - 1);               // now inside the CHECK cycle
        bus.io_rdn = 1'b0;
        cyc(3);
        bus.io_rdn = 1'b1;
        cyc(4);
        ps2_clk = 1'b1;
        cyc(4);
        model_pop();
        model_frame(b, 1'b0);
        vectors++;
        if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL fullpop_ovf got=%b want=0", bus.overflow); end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (bus.ready !== 1'b1 || bus.key_data !== m_head()) begin
                miscompares++; $display("FAIL fullpop_read%0d got=%b/%h want=1/%h", i, bus.ready, bus.key_data, m_head());
            end
            pop_pulse(2);
        end
        vectors++;
        if (bus.ready !== 1'b0 || bus.key_data !== 8'h0A) begin
            miscompares++; $display("FAIL fullpop_last got=%b/%h want=0/0a", bus.ready, bus.key_data);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        cyc(TIMEOUT_CYCLES + 50);
        vectors++;
        if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL tmo_ready got=%b want=0", bus.ready); end
        send_frame(8'h29, 1'b0, 1'b0);
        vectors++;
        if (bus.ready !== 1'b1 || bus.key_data !== 8'h29) begin
            miscompares++; $display("FAIL tmo_next got=%b/%h want=1/29", bus.ready, bus.key_data);
        end
        pop_pulse(2);
        ps2_bit(1'b1);              // lone falling edge with data high
        ps2_data = 1'b1;
        cyc(20);
        vectors++;
        if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL false_start got=%b want=0", bus.ready); end
        send_frame(8'h33, 1'b0, 1'b0);
        vectors++;
        if (bus.ready !== 1'b1 || bus.key_data !== 8'h33) begin
            miscompares++; $display("FAIL false_start_next got=%b/%h want=1/33", bus.ready, bus.key_data);
        end
    endtask

    task automatic test_parity_reset();
        do_reset();
`ifdef PS2_PARITY_CHECK_EN
        send_frame(8'h1C, 1'b1, 1'b0);
        vectors++;
        if (bus.parity_err !== 1'b1 || bus.ready !== 1'b0) begin
            miscompares++; $display("FAIL parity_bad got=%b/%b want=1/0", bus.parity_err, bus.ready);
        end
        send_frame(8'h11, 1'b0, 1'b0);
        vectors++;
        if (bus.parity_err !== 1'b0 || bus.key_data !== 8'h11) begin
            miscompares++; $display("FAIL parity_clear got=%b/%h want=0/11", bus.parity_err, bus.key_data);
        end
        send_frame(8'h22, 1'b0, 1'b1);
`else
        send_frame(8'h11, 1'b0, 1'b0);
`endif
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        model_reset();
        vectors++;
        if (bus.ready !== 1'b0 || bus.key_data !== 8'h00 || bus.overflow !== 1'b0 || bus.parity_err !== 1'b0) begin
            miscompares++; $display("FAIL midreset got=%b/%h/%b/%b want=0/00/0/0", bus.ready, bus.key_data, bus.overflow, bus.parity_err);
        end
        ps2_data = 1'b1;
        cyc(20);
        send_frame(8'h5A, 1'b0, 1'b0);
        vectors++;
        if (bus.ready !== 1'b1 || bus.key_data !== 8'h5A) begin
            miscompares++; $display("FAIL after_reset got=%b/%h want=1/5a", bus.ready, bus.key_data);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       bp;
        logic       bs;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 6) begin
                b  = 8'($urandom);
                bp = ($urandom_range(0, 5) == 0);
                bs = ($urandom_range(0, 9) == 0);
                send_frame(b, bp, bs);
            end else begin
                pop_pulse($urandom_range(1, 30));
            end
            vectors++;
            if (bus.ready !== (mq.size() != 0) || bus.key_data !== m_head() ||
                bus.overflow !== m_ovf || bus.parity_err !== m_perr) begin
                miscompares++;
                $display("FAIL rand%0d got=%b/%h/%b/%b want=%b/%h/%b/%b", n,
                         bus.ready, bus.key_data, bus.overflow, bus.parity_err,
                         (mq.size() != 0), m_head(), m_ovf, m_perr);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        bus.io_rdn = 1'b1;
        model_reset();
        cyc(3);
        test_reset();
        test_single_frame();
        test_make_break();
        test_overflow();
        test_full_pop();
        test_timeout();
        test_parity_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
